// File: rtl/msk_rx_acq_ctrl_if.sv
// Control/status bundle between the MSK RX acquisition sequencer and the RX chain.
// The master side drives the start level, strobes and phase error; the slave side is the sequencer.
interface msk_rx_acq_ctrl_if #(
   parameter int EW = 24,
   parameter int CW = 16
);
   logic                 start_i;
   logic                 sym_val_i;
   logic                 err_val_i;
   logic signed [EW-1:0] phase_err_i;
   logic                 timing_en_o;
   logic                 cfo_en_o;
   logic                 loop_clr_o;
   logic                 locked_o;
   logic                 fail_o;
   logic [2:0]           state_o;
   logic [CW-1:0]        retry_o;

   modport master (
      output start_i, sym_val_i, err_val_i, phase_err_i,
      input  timing_en_o, cfo_en_o, loop_clr_o, locked_o, fail_o, state_o, retry_o
   );

   modport slave (
      input  start_i, sym_val_i, err_val_i, phase_err_i,
      output timing_en_o, cfo_en_o, loop_clr_o, locked_o, fail_o, state_o, retry_o
   );
endinterface

// File: rtl/msk_rx_acq_ctrl.sv
// MSK receiver acquisition sequencer: timing acquisition, CFO acquisition with lock
// detection from phase-error magnitude, loss-of-lock handling and bounded retries.
module msk_rx_acq_ctrl #(
   parameter int EW         = 24,
   parameter int CW         = 16,
   parameter int TIM_SYMS   = 256,
   parameter int LOCK_THR   = 4096,
   parameter int LOCK_RUN   = 64,
   parameter int UNLOCK_RUN = 16,
   parameter int ACQ_TMO    = 4096,
   parameter int MAX_RETRY  = 3
) (
   input logic               clk,
   input logic               rst,
   msk_rx_acq_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_TIM_ACQ = 3'd1,
      S_CFO_ACQ = 3'd2,
      S_TRACK   = 3'd3,
      S_FAIL    = 3'd4
   } state_t;

   localparam logic [CW-1:0] CNT_MAX    = '1;
   localparam logic [CW-1:0] TIM_LAST   = CW'(TIM_SYMS - 1);
   localparam logic [CW-1:0] TMO_LAST   = CW'(ACQ_TMO - 1);
   localparam logic [CW-1:0] LOCK_CNT   = CW'(LOCK_RUN);
   localparam logic [CW-1:0] UNLOCK_CNT = CW'(UNLOCK_RUN);
   localparam logic [CW-1:0] RETRY_MAX  = CW'(MAX_RETRY);
   localparam logic [EW-1:0] ERR_MIN    = {1'b1, {(EW-1){1'b0}}};
   localparam logic [EW-1:0] ERR_MAX    = {1'b0, {(EW-1){1'b1}}};
   localparam logic [EW:0]   THR        = (EW+1)'(LOCK_THR);

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   state_t        r_state;
   logic [CW-1:0] r_sym_cnt;
   logic [CW-1:0] r_good_run;
   logic [CW-1:0] r_bad_run;
   logic [CW-1:0] r_retry;
   logic          r_timing_en;
   logic          r_cfo_en;
   logic          r_loop_clr;
   logic          r_locked;
   logic          r_fail;

   state_t        w_state_nxt;
   logic [CW-1:0] w_sym_nxt;
   logic [CW-1:0] w_good_nxt;
   logic [CW-1:0] w_bad_nxt;
   logic [CW-1:0] w_retry_nxt;
   logic [CW-1:0] w_good_inc;
   logic [CW-1:0] w_bad_inc;
   logic [CW-1:0] w_retry_inc;
   logic [EW-1:0] w_abs;
   logic          w_good;

   // The most negative error has no positive twin, so it clamps to the largest magnitude.
   always_comb begin
      if ($unsigned(bus.phase_err_i) == ERR_MIN) begin
         w_abs = ERR_MAX;
      end else if (bus.phase_err_i[EW-1]) begin
         w_abs = $unsigned(-bus.phase_err_i);
      end else begin
         w_abs = $unsigned(bus.phase_err_i);
      end
   end

   assign w_good = ({1'b0, w_abs} <= THR);

   always_comb begin
      // NOTE: every signal gets a default before any branch so no path can infer a latch.
      w_state_nxt = r_state;
      w_sym_nxt   = r_sym_cnt;
      w_good_nxt  = r_good_run;
      w_bad_nxt   = r_bad_run;
      w_retry_nxt = r_retry;
      w_good_inc  = sat_inc(r_good_run);
      w_bad_inc   = sat_inc(r_bad_run);
      w_retry_inc = (r_retry >= RETRY_MAX) ? RETRY_MAX : r_retry + 1'b1;

      if (!bus.start_i) begin
         w_state_nxt = S_IDLE;
         w_sym_nxt   = '0;
         w_good_nxt  = '0;
         w_bad_nxt   = '0;
         w_retry_nxt = '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               w_state_nxt = S_TIM_ACQ;
               w_sym_nxt   = '0;
            end
            S_TIM_ACQ: begin
               if (bus.sym_val_i) begin
                  if (r_sym_cnt >= TIM_LAST) begin
                     w_state_nxt = S_CFO_ACQ;
                     w_sym_nxt   = '0;
                     w_good_nxt  = '0;
                  end else begin
                     w_sym_nxt = sat_inc(r_sym_cnt);
                  end
               end
            end
            S_CFO_ACQ: begin
               if (bus.err_val_i) w_good_nxt = w_good ? w_good_inc : '0;
               if (bus.sym_val_i) w_sym_nxt = sat_inc(r_sym_cnt);
               // Lock is tested first so it wins over a coincident timeout.
               if (bus.err_val_i && w_good && (w_good_inc >= LOCK_CNT)) begin
                  w_state_nxt = S_TRACK;
                  w_retry_nxt = '0;
                  w_bad_nxt   = '0;
               end else if (bus.sym_val_i && (r_sym_cnt >= TMO_LAST)) begin
                  w_retry_nxt = w_retry_inc;
                  if (w_retry_inc >= RETRY_MAX) begin
                     w_state_nxt = S_FAIL;
                  end else begin
                     w_state_nxt = S_TIM_ACQ;
                     w_sym_nxt   = '0;
                  end
               end
            end
            S_TRACK: begin
               if (bus.err_val_i) begin
                  if (w_good) begin
                     w_bad_nxt = '0;
                  end else if (w_bad_inc >= UNLOCK_CNT) begin
                     w_state_nxt = S_CFO_ACQ;
                     w_sym_nxt   = '0;
                     w_good_nxt  = '0;
                     w_bad_nxt   = '0;
                  end else begin
                     w_bad_nxt = w_bad_inc;
                  end
               end
            end
            S_FAIL: begin
               w_state_nxt = S_FAIL;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         r_state     <= S_IDLE;
         r_sym_cnt   <= '0;
         r_good_run  <= '0;
         r_bad_run   <= '0;
         r_retry     <= '0;
         r_timing_en <= 1'b0;
         r_cfo_en    <= 1'b0;
         r_loop_clr  <= 1'b0;
         r_locked    <= 1'b0;
         r_fail      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_sym_cnt   <= w_sym_nxt;
         r_good_run  <= w_good_nxt;
         r_bad_run   <= w_bad_nxt;
         r_retry     <= w_retry_nxt;
         // Flags follow the next state so they line up with state_o.
         r_timing_en <= (w_state_nxt == S_TIM_ACQ) || (w_state_nxt == S_CFO_ACQ) ||
                        (w_state_nxt == S_TRACK);
         r_cfo_en    <= (w_state_nxt == S_CFO_ACQ) || (w_state_nxt == S_TRACK);
         r_loop_clr  <= (w_state_nxt == S_CFO_ACQ) && (r_state != S_CFO_ACQ);
         r_locked    <= (w_state_nxt == S_TRACK);
         r_fail      <= (w_state_nxt == S_FAIL);
      end
   end

   assign bus.state_o     = r_state;
   assign bus.timing_en_o = r_timing_en;
   assign bus.cfo_en_o    = r_cfo_en;
   assign bus.loop_clr_o  = r_loop_clr;
   assign bus.locked_o    = r_locked;
   assign bus.fail_o      = r_fail;
   assign bus.retry_o     = r_retry;

endmodule

// File: tb/tb_msk_rx_acq_ctrl.sv
// Directed bench for msk_rx_acq_ctrl: stimulus queues hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_msk_rx_acq_ctrl;
   localparam int EW = 24;
   localparam int CW = 16;

   localparam int S_IDLE  = 0;
   localparam int S_TIM   = 1;
   localparam int S_CFO   = 2;
   localparam int S_TRACK = 3;
   localparam int S_FAIL  = 4;

   localparam int ERR_NEG_FULL = -8388608;

   typedef struct {
      int          cyc;
      logic [23:0] exp;
      string       name;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb_q[$];

   int t3_err [6] = '{500, 500, 50, 500, 500, 500};
   int t2_err [8] = '{50, 50, 50, -200, 50, 50, 50, 50};
   int bnd_err[8] = '{101, -101, -100, 101, 100, 101, ERR_NEG_FULL, ERR_NEG_FULL};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   msk_rx_acq_ctrl_if #(.EW(EW), .CW(CW)) bus ();

   msk_rx_acq_ctrl #(
      .EW(EW), .CW(CW), .TIM_SYMS(8), .LOCK_THR(100), .LOCK_RUN(4),
      .UNLOCK_RUN(3), .ACQ_TMO(20), .MAX_RETRY(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Packed as {state, timing_en, cfo_en, loop_clr, locked, fail, retry}.
   logic [23:0] got;
   assign got = {bus.state_o, bus.timing_en_o, bus.cfo_en_o, bus.loop_clr_o,
                 bus.locked_o, bus.fail_o, bus.retry_o};

   function automatic logic [23:0] pack_exp(input int st, input int clr, input int rt);
      logic ten, cen, lck, fl;
      ten = (st == S_TIM) || (st == S_CFO) || (st == S_TRACK);
      cen = (st == S_CFO) || (st == S_TRACK);
      lck = (st == S_TRACK);
      fl  = (st == S_FAIL);
      return {3'(st), ten, cen, (clr != 0), lck, fl, 16'(rt)};
   endfunction

   task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got state=%0d ten=%b cen=%b clr=%b lck=%b fail=%b retry=%0d, want state=%0d ten=%b cen=%b clr=%b lck=%b fail=%b retry=%0d",
                  name, act[23:21], act[20], act[19], act[18], act[17], act[16], act[15:0],
                  exp[23:21], exp[20], exp[19], exp[18], exp[17], exp[16], exp[15:0]);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (sb_q.size() != 0 && sb_q[0].cyc == cyc) begin
         e = sb_q.pop_front();
         check(e.name, got, e.exp);
      end
   end

   // Drives one cycle of inputs and queues the outputs expected after the following edge.
   task automatic step(input string name, input int r, input int st, input int sv, input int ev,
                       input int err, input int exp_st, input int exp_clr, input int exp_rt);
      exp_t e;
      logic [31:0] err_bits;
      @(negedge clk);
      err_bits        = err;
      rst             = (r != 0);
      bus.start_i     = (st != 0);
      bus.sym_val_i   = (sv != 0);
      bus.err_val_i   = (ev != 0);
      bus.phase_err_i = err_bits[EW-1:0];
      e.cyc  = cyc + 1;
      e.exp  = pack_exp(exp_st, exp_clr, exp_rt);
      e.name = name;
      sb_q.push_back(e);
   endtask

   initial begin
      bus.start_i     = 1'b0;
      bus.sym_val_i   = 1'b0;
      bus.err_val_i   = 1'b0;
      bus.phase_err_i = '0;

      step("reset_idle", 1, 0, 0, 0, 0, S_IDLE, 0, 0);
      step("reset_overrides_start", 1, 1, 1, 1, 50, S_IDLE, 0, 0);

      // Nominal acquisition to lock
      step("t1_start", 0, 1, 0, 0, 0, S_TIM, 0, 0);
      for (int i = 0; i < 7; i++) step("t1_tim_sym", 0, 1, 1, 1, 500, S_TIM, 0, 0);
      step("t1_8th_sym_to_cfo", 0, 1, 1, 0, 0, S_CFO, 1, 0);
      for (int i = 0; i < 3; i++) step("t1_good_err", 0, 1, 0, 1, 50, S_CFO, 0, 0);
      step("t1_lock", 0, 1, 0, 1, 50, S_TRACK, 0, 0);

      // Loss of lock
      for (int i = 0; i < 5; i++) step("t3_track", 0, 1, 0, 1, t3_err[i], S_TRACK, 0, 0);
      step("t3_unlock", 0, 1, 0, 1, t3_err[5], S_CFO, 1, 0);

      // Good-run reset by one bad error
      for (int i = 0; i < 7; i++) step("t2_cfo", 0, 1, 0, 1, t2_err[i], S_CFO, 0, 0);
      step("t2_lock_8th", 0, 1, 0, 1, t2_err[7], S_TRACK, 0, 0);

      // Threshold boundary and most-negative error in TRACK
      for (int i = 0; i < 7; i++) step("bnd_track", 0, 1, 0, 1, bnd_err[i], S_TRACK, 0, 0);
      step("bnd_neg_full_unlock", 0, 1, 0, 1, bnd_err[7], S_CFO, 1, 0);

      // Timeout, retry and FAIL
      for (int i = 0; i < 19; i++) step("t4_cfo_bad", 0, 1, 1, 1, 500, S_CFO, 0, 0);
      step("t4_timeout1", 0, 1, 1, 1, 500, S_TIM, 0, 1);
      for (int i = 0; i < 7; i++) step("t4_tim", 0, 1, 1, 0, 0, S_TIM, 0, 1);
      step("t4_reenter_cfo", 0, 1, 1, 0, 0, S_CFO, 1, 1);
      for (int i = 0; i < 19; i++)
         step("t4_cfo_mixed", 0, 1, 1, 1, (i % 4 == 3) ? -300 : 20, S_CFO, 0, 1);
      step("t4_timeout2_fail", 0, 1, 1, 1, -300, S_FAIL, 0, 2);
      for (int i = 0; i < 3; i++) step("t4_fail_sticky", 0, 1, 1, 1, 50, S_FAIL, 0, 2);
      step("t4_stop_to_idle", 0, 0, 0, 0, 0, S_IDLE, 0, 0);
      step("t4_idle_ignores", 0, 0, 1, 1, 50, S_IDLE, 0, 0);

      // Lock coinciding with timeout, then reset in TRACK, then stop in TIM_ACQ
      step("t5_start", 0, 1, 0, 0, 0, S_TIM, 0, 0);
      for (int i = 0; i < 7; i++) step("t5_tim", 0, 1, 1, 0, 0, S_TIM, 0, 0);
      step("t5_to_cfo", 0, 1, 1, 0, 0, S_CFO, 1, 0);
      for (int i = 0; i < 19; i++) step("t5_cfo_syms", 0, 1, 1, 0, 0, S_CFO, 0, 0);
      step("t5_timeout", 0, 1, 1, 0, 0, S_TIM, 0, 1);
      for (int i = 0; i < 7; i++) step("t5_tim2", 0, 1, 1, 0, 0, S_TIM, 0, 1);
      step("t5_to_cfo2", 0, 1, 1, 0, 0, S_CFO, 1, 1);
      for (int i = 0; i < 16; i++) step("t5_cfo_syms2", 0, 1, 1, 0, 0, S_CFO, 0, 1);
      for (int i = 0; i < 3; i++) step("t5_good_with_sym", 0, 1, 1, 1, 50, S_CFO, 0, 1);
      step("t5_lock_beats_timeout", 0, 1, 1, 1, 50, S_TRACK, 0, 0);
      step("t5_rst_in_track", 1, 1, 1, 1, 50, S_IDLE, 0, 0);
      step("t5_restart", 0, 1, 0, 0, 0, S_TIM, 0, 0);
      for (int i = 0; i < 3; i++) step("t5_tim3", 0, 1, 1, 0, 0, S_TIM, 0, 0);
      step("t5_stop_in_tim", 0, 0, 1, 0, 0, S_IDLE, 0, 0);
      step("t5_idle_hold", 0, 0, 0, 0, 0, S_IDLE, 0, 0);

      repeat (3) @(negedge clk);
      #1;
      if (sb_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
